// File: rtl/button_cmd_scheduler_pkg.sv
// Shared constants for the button command scheduler: 10 kHz timing, button indices,
// the command id width derivation and the per-button event record.
package button_cmd_scheduler_pkg;

  localparam int N_BTN_DEF         = 4;
  localparam int HOLD_CYCLES_DEF   = 5000;  // 0.5 s at 10 kHz
  localparam int REPEAT_CYCLES_DEF = 2000;  // 0.2 s at 10 kHz
  localparam int CNT_W_DEF         = 13;

  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_SEL  = 2;
  localparam int BTN_MODE = 3;

  function automatic int id_width(input int n_btn);
    return (n_btn <= 2) ? 1 : $clog2(n_btn);
  endfunction

  localparam int ID_W_DEF = id_width(N_BTN_DEF);

  typedef struct packed {
    logic press;
    logic rpt;
  } btn_evt_t;

endpackage

// File: rtl/button_cmd_scheduler_hold_timer.sv
// One button: edge detect, hold counter with first/subsequent repeat phase, and
// registered press/repeat pulses.
module btn_hold_timer
  import button_cmd_scheduler_pkg::*;
#(
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic     Clock,
  input  logic     Reset,
  input  logic     level_i,
  output btn_evt_t evt_o
);

  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_CYCLES - 1);

  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  btn_evt_t         evt_q;
  logic             press_s;
  logic             rpt_s;
  logic [CNT_W-1:0] term_s;

  // Edge detect and hold counter next state
  always_comb begin
    press_s = level_i & ~prev_q;
    term_s  = phase_q ? REP_TERM : HOLD_TERM;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    rpt_s   = 1'b0;
    if (!level_i || press_s) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == term_s) begin
      cnt_d   = '0;
      phase_d = 1'b1;
      rpt_s   = 1'b1;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // prev resets high so a button held through reset needs a fresh press
  always_ff @(posedge Clock) begin
    if (Reset) begin
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      evt_q   <= '0;
    end else begin
      prev_q    <= level_i;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      evt_q.press <= press_s;
      evt_q.rpt   <= rpt_s;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/button_cmd_scheduler.sv
// Turns debounced button levels into one-at-a-time commands (press and auto-repeat)
// with round-robin arbitration and a valid/ready output register.
module button_cmd_scheduler
  import button_cmd_scheduler_pkg::*;
#(
  parameter int N_BTN         = N_BTN_DEF,
  parameter int ID_W          = ID_W_DEF,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [N_BTN-1:0] Btn_Level_i,
  input  logic             Cmd_Ready_i,
  output logic             Cmd_Valid_o,
  output logic [ID_W-1:0]  Cmd_Id_o,
  output logic             Cmd_Repeat_o,
  output logic             Overrun_o
);

  btn_evt_t evt_s [N_BTN];

  for (genvar g = 0; g < N_BTN; g++) begin : g_timer
    btn_hold_timer #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
    ) u_timer (
      .Clock  (Clock),
      .Reset  (Reset),
      .level_i(Btn_Level_i[g]),
      .evt_o  (evt_s[g])
    );
  end

  logic [N_BTN-1:0] pending_q, pending_d;
  logic [N_BTN-1:0] rep_q, rep_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             crep_q, crep_d;
  logic             ovr_q, ovr_d;

  logic             free_s;
  logic             found_s;
  logic             grant_s;
  logic [ID_W-1:0]  gidx_s;
  logic [ID_W-1:0]  scan_s;
  logic [ID_W-1:0]  nxt_ptr_s;
  logic [N_BTN-1:0] gnt_vec_s;
  logic [N_BTN-1:0] ev_vec_s;
  logic [N_BTN-1:0] evrep_vec_s;

  // Round-robin scan: walking downward leaves the nearest pending index at/after ptr
  always_comb begin
    free_s  = ~valid_q | Cmd_Ready_i;
    found_s = 1'b0;
    gidx_s  = '0;
    scan_s  = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      scan_s  = ID_W'((int'(ptr_q) + k) % N_BTN);
      found_s = found_s | pending_q[scan_s];
      gidx_s  = pending_q[scan_s] ? scan_s : gidx_s;
    end
    grant_s   = free_s & found_s;
    nxt_ptr_s = (gidx_s == ID_W'(N_BTN - 1)) ? '0 : gidx_s + ID_W'(1);
  end

  // Pending latches: a same-cycle event wins over the grant's clear
  always_comb begin
    pending_d   = pending_q;
    rep_d       = rep_q;
    ovr_d       = ovr_q;
    gnt_vec_s   = '0;
    ev_vec_s    = '0;
    evrep_vec_s = '0;
    for (int i = 0; i < N_BTN; i++) begin
      gnt_vec_s[i]   = grant_s & (gidx_s == ID_W'(i));
      ev_vec_s[i]    = evt_s[i].press | evt_s[i].rpt;
      evrep_vec_s[i] = evt_s[i].rpt;
      if (ev_vec_s[i]) begin
        pending_d[i] = 1'b1;
        if (pending_q[i] && !gnt_vec_s[i]) begin
          rep_d[i] = rep_q[i] | evrep_vec_s[i];
          ovr_d    = 1'b1;
        end else begin
          rep_d[i] = evrep_vec_s[i];
        end
      end else if (gnt_vec_s[i]) begin
        pending_d[i] = 1'b0;
        rep_d[i]     = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
        rep_d[i]     = rep_q[i];
      end
    end
  end

  // Output presenter: load on free, otherwise hold the presented command
  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    crep_d  = crep_q;
    ptr_d   = ptr_q;
    if (free_s) begin
      if (found_s) begin
        valid_d = 1'b1;
        id_d    = gidx_s;
        crep_d  = rep_q[gidx_s];
        ptr_d   = nxt_ptr_s;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pending_q <= '0;
      rep_q     <= '0;
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      crep_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      rep_q     <= rep_d;
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      crep_q    <= crep_d;
      ovr_q     <= ovr_d;
    end
  end

  assign Cmd_Valid_o  = valid_q;
  assign Cmd_Id_o     = id_q;
  assign Cmd_Repeat_o = crep_q;
  assign Overrun_o    = ovr_q;

endmodule

// File: tb/tb_button_cmd_scheduler.sv
// Directed bench for button_cmd_scheduler: latency, hold stability, round-robin order,
// auto-repeat timing, overrun and reset behaviour against hand-computed expectations.
module tb_button_cmd_scheduler;

  logic       Clock;
  logic       Reset;
  logic [3:0] btn;
  logic       ready;
  logic       valid;
  logic [1:0] id;
  logic       rep;
  logic       ovr;

  int n_vec;
  int n_err;
  int ev_tick [16];
  int ev_id   [16];
  int ev_rep  [16];
  int n_ev;
  int seen;

  button_cmd_scheduler dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Btn_Level_i (btn),
    .Cmd_Ready_i (ready),
    .Cmd_Valid_o (valid),
    .Cmd_Id_o    (id),
    .Cmd_Repeat_o(rep),
    .Overrun_o   (ovr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic check_cmd(input string tag, input int v, input int i, input int r);
    check_val({tag, "_valid"}, 32'(valid), v);
    check_val({tag, "_id"}, 32'(id), i);
    check_val({tag, "_rep"}, 32'(rep), r);
  endtask

  // Drive a pattern high for 'hold' ticks and log every presented command (Cmd_Ready high)
  task automatic run_hold(input logic [3:0] pattern, input int hold, input int total);
    for (int i = 0; i < 16; i++) begin
      ev_tick[i] = -1;
      ev_id[i]   = -1;
      ev_rep[i]  = -1;
    end
    n_ev = 0;
    btn  = pattern;
    for (int k = 1; k <= total; k++) begin
      tick();
      if (k == hold) btn = 4'b0000;
      if (valid && n_ev < 16) begin
        ev_tick[n_ev] = k;
        ev_id[n_ev]   = 32'(id);
        ev_rep[n_ev]  = 32'(rep);
        n_ev++;
      end
    end
  endtask

  task automatic expect_ev(input string tag, input int i, input int t, input int bid, input int r);
    check_val({tag, "_tick"}, ev_tick[i], t);
    check_val({tag, "_id"}, ev_id[i], bid);
    check_val({tag, "_rep"}, ev_rep[i], r);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset = 1'b1;
    btn   = 4'b0001;
    ready = 1'b0;

    // Reset with btn0 held, then no command until it is released and re-pressed
    tick();
    tick();
    check_val("rst_valid", 32'(valid), 0);
    check_val("rst_id", 32'(id), 0);
    check_val("rst_rep", 32'(rep), 0);
    check_val("rst_ovr", 32'(ovr), 0);
    Reset = 1'b0;
    seen  = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (valid) seen++;
    end
    check_val("held_thru_reset", seen, 0);
    btn = 4'b0000;
    tick();
    tick();
    btn = 4'b0001;
    tick();
    check_val("lat_t0", 32'(valid), 0);
    tick();
    check_val("lat_t1", 32'(valid), 0);
    tick();
    check_cmd("lat_t2", 1, 0, 0);
    ready = 1'b1;
    tick();
    check_val("accept_idle", 32'(valid), 0);
    btn   = 4'b0000;
    ready = 1'b0;

    // Stability while stalled
    btn = 4'b0100;
    tick();
    btn = 4'b0000;
    tick();
    tick();
    check_cmd("stall_first", 1, 2, 0);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (valid !== 1'b1 || id !== 2'd2) seen++;
    end
    check_val("stall_hold", seen, 0);
    ready = 1'b1;
    tick();
    check_val("stall_release", 32'(valid), 0);
    check_val("stall_ovr", 32'(ovr), 0);

    // Round-robin: simultaneous press, simultaneous repeat, then pointer-ordered pair
    do_reset();
    run_hold(4'b1001, 5005, 5010);
    check_val("rr_count", n_ev, 4);
    expect_ev("rr_p0", 0, 3, 0, 0);
    expect_ev("rr_p3", 1, 4, 3, 0);
    expect_ev("rr_r0", 2, 5003, 0, 1);
    expect_ev("rr_r3", 3, 5004, 3, 1);
    run_hold(4'b1010, 1, 8);
    check_val("rr_pair_count", n_ev, 2);
    expect_ev("rr_b1", 0, 3, 1, 0);
    expect_ev("rr_b3", 1, 4, 3, 0);

    // Long hold: press, then repeats 5000/7000/9000 cycles after it
    run_hold(4'b0010, 9001, 9010);
    check_val("hold_count", n_ev, 4);
    expect_ev("hold_press", 0, 3, 1, 0);
    expect_ev("hold_r1", 1, 5003, 1, 1);
    expect_ev("hold_r2", 2, 7003, 1, 1);
    expect_ev("hold_r3", 3, 9003, 1, 1);

    // Release one cycle before the first repeat, then a fresh full wait
    run_hold(4'b0100, 5000, 5010);
    check_val("short_count", n_ev, 1);
    expect_ev("short_press", 0, 3, 2, 0);
    run_hold(4'b0100, 5001, 5010);
    check_val("again_count", n_ev, 2);
    expect_ev("again_press", 0, 3, 2, 0);
    expect_ev("again_r1", 1, 5003, 2, 1);

    // Overrun: presented + pending, then a third press merges
    ready = 1'b0;
    for (int p = 0; p < 2; p++) begin
      btn = 4'b0010;
      tick();
      btn = 4'b0000;
      for (int k = 0; k < 19; k++) tick();
    end
    check_cmd("ovr_present", 1, 1, 0);
    check_val("ovr_before", 32'(ovr), 0);
    btn = 4'b0010;
    tick();
    btn = 4'b0000;
    tick();
    tick();
    tick();
    check_val("ovr_set", 32'(ovr), 1);
    ready = 1'b1;
    tick();
    check_cmd("ovr_second", 1, 1, 0);
    tick();
    check_val("ovr_drained", 32'(valid), 0);
    check_val("ovr_sticky", 32'(ovr), 1);

    // Reset mid-handshake drops the command and clears Overrun
    ready = 1'b0;
    btn   = 4'b1000;
    tick();
    btn = 4'b0000;
    tick();
    tick();
    check_cmd("mid_present", 1, 3, 0);
    Reset = 1'b1;
    tick();
    check_cmd("mid_reset", 0, 0, 0);
    check_val("mid_ovr", 32'(ovr), 0);
    Reset = 1'b0;
    seen  = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (valid) seen++;
    end
    check_val("mid_after", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
